// File: rtl/sum_window_pkg.sv
// ---------------------------------------------------------------------------
// sum_window_pkg
// Shared definitions for the windowed sum accumulator:
//   - default sample width and window length
//   - FSM state encoding (ACCUM / HOLD)
//   - width derivation helpers for the accumulator and fill counter
// ---------------------------------------------------------------------------
package sum_window_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_WINDOW = 4;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // The sum of WINDOW samples of all-ones needs log2(WINDOW) extra bits.
    function automatic int acc_width(input int data_w, input int window);
        return data_w + $clog2(window);
    endfunction

    // The fill counter must be able to count 0..WINDOW-1. The extra bit
    // keeps the width non-zero when WINDOW is 1.
    function automatic int cnt_width(input int window);
        return $clog2(window) + 1;
    endfunction

endpackage

// File: rtl/sum_window_out_reg.sv
// ---------------------------------------------------------------------------
// sum_window_out_reg
// Valid/ready holding register for the window result.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous reset, active low
//   i_clear  in   synchronous clear, drops any pending result
//   i_load   in   capture i_data and raise o_valid
//   i_take   in   consumer accepted the result this cycle
//   i_data   in   ACC_W result to capture
//   o_data   out  ACC_W held result
//   o_valid  out  result present
// ---------------------------------------------------------------------------
module sum_window_out_reg #(
    parameter int ACC_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_take,
    input  logic [ACC_W-1:0] i_data,
    output logic [ACC_W-1:0] o_data,
    output logic             o_valid
);

    logic [ACC_W-1:0] r_data;
    logic             r_valid;

    // A load in the same cycle as a take replaces the departing result, so
    // load is checked before take and valid stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_take) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/sum_window_accum.sv
// ---------------------------------------------------------------------------
// sum_window_accum
// Accumulates WINDOW adder-sum samples (valid/ready in) and presents the
// window total on a registered valid/ready output.
// Optional build macro: SUM_WINDOW_AVG_EN -- when defined, the result is the
// window mean (sum >> log2(WINDOW), floor) instead of the raw sum.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous reset, active low
//   clear      in   synchronous clear of window and output register
//   in_data    in   DATA_W sample
//   in_valid   in   sample present
//   in_ready   out  sample can be accepted this cycle
//   out_data   out  ACC_W window result
//   out_valid  out  result present
//   out_ready  in   consumer takes result this cycle
//   fill       out  CNT_W samples accumulated in current window
// WINDOW must be a power of two >= 1.
// ---------------------------------------------------------------------------
module sum_window_accum
    import sum_window_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int WINDOW = DEF_WINDOW
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic [DATA_W-1:0]                   in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [acc_width(DATA_W, WINDOW)-1:0] out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [cnt_width(WINDOW)-1:0]        fill
);

    localparam int ACC_W = acc_width(DATA_W, WINDOW);
    localparam int CNT_W = cnt_width(WINDOW);
    localparam int SHIFT = $clog2(WINDOW);

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_fill;

    logic             w_accept;
    logic             w_take;
    logic             w_last;
    logic             w_out_valid;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_result;

    function automatic logic [ACC_W-1:0] f_result(input logic [ACC_W-1:0] sum);
`ifdef SUM_WINDOW_AVG_EN
        return sum >> SHIFT;
`else
        return sum;
`endif
    endfunction

    // In HOLD the accumulator and fill are already zero, so a sample accepted
    // alongside a transfer naturally starts the next window; with WINDOW==1
    // that same sample is also the last one and the block stays in HOLD.
    assign in_ready = !clear && ((r_state == ACCUM) || ((r_state == HOLD) && out_ready));
    assign w_accept = in_valid && in_ready;
    assign w_take   = w_out_valid && out_ready;
    assign w_last   = (r_fill == CNT_W'(WINDOW - 1));
    assign w_sum    = r_acc + ACC_W'(in_data);
    assign w_result = f_result(w_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_fill  <= '0;
        end else if (clear) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_fill  <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_state <= HOLD;
                r_acc   <= '0;
                r_fill  <= '0;
            end else begin
                r_state <= ACCUM;
                r_acc   <= w_sum;
                r_fill  <= r_fill + CNT_W'(1);
            end
        end else if (w_take) begin
            r_state <= ACCUM;
        end
    end

    sum_window_out_reg #(
        .ACC_W (ACC_W)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (clear),
        .i_load  (w_accept && w_last),
        .i_take  (w_take),
        .i_data  (w_result),
        .o_data  (out_data),
        .o_valid (w_out_valid)
    );

    assign out_valid = w_out_valid;
    assign fill      = r_fill;

endmodule

// File: tb/tb_sum_window_accum.sv
module tb_sum_window_accum;

`ifdef SUM_WINDOW_AVG_EN
    localparam int E_100  = 25;
    localparam int E_1020 = 255;
    localparam int E_10   = 2;
    localparam int E_4    = 1;
    localparam int E_12   = 3;
    localparam int E_20   = 5;
`else
    localparam int E_100  = 100;
    localparam int E_1020 = 1020;
    localparam int E_10   = 10;
    localparam int E_4    = 4;
    localparam int E_12   = 12;
    localparam int E_20   = 20;
`endif

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fill;

    int n_vec = 0;
    int n_err = 0;

    sum_window_accum #(
        .DATA_W (8),
        .WINDOW (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fill      (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data),  0);
        chk("rst_fill",      32'(fill),      0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);

        // back-to-back window 10,20,30,40
        send(8'd10); chk("t1_fill1", 32'(fill), 1);
        send(8'd20); chk("t1_fill2", 32'(fill), 2);
        send(8'd30); chk("t1_fill3", 32'(fill), 3);
        chk("t1_no_early_valid", 32'(out_valid), 0);
        send(8'd40);
        chk("t1_fill0",  32'(fill),      0);
        chk("t1_valid",  32'(out_valid), 1);
        chk("t1_data",   32'(out_data),  E_100);
        tick();
        chk("t1_xfer",   32'(out_valid), 0);

        // max-value window
        repeat (4) send(8'd255);
        chk("t2_valid", 32'(out_valid), 1);
        chk("t2_data",  32'(out_data),  E_1020);
        tick();
        chk("t2_xfer",  32'(out_valid), 0);

        // back-pressure: result held, extra samples refused
        out_ready = 1'b0;
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        in_valid = 1'b1;
        in_data  = 8'd99;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", 32'(out_valid), 1);
            chk("t3_hold_data",  32'(out_data),  E_10);
            chk("t3_in_ready",   32'(in_ready),  0);
            chk("t3_hold_fill",  32'(fill),      0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("t3_ready_on_take", 32'(in_ready), 1);
        tick();
        chk("t3_xfer",      32'(out_valid), 0);
        chk("t3_fill_after", 32'(fill),     0);

        // transfer with simultaneous accept starts next window
        out_ready = 1'b0;
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        chk("t4_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        send(8'd7);
        chk("t4_xfer",  32'(out_valid), 0);
        chk("t4_fill1", 32'(fill),      1);
        send(8'd1); chk("t4_fill2", 32'(fill), 2);
        send(8'd1); chk("t4_fill3", 32'(fill), 3);
        send(8'd1);
        chk("t4_valid2", 32'(out_valid), 1);
        chk("t4_data2",  32'(out_data),  E_10);
        tick();
        chk("t4_xfer2",  32'(out_valid), 0);

        // clear mid-window discards partial sum
        send(8'd50); send(8'd60);
        chk("t5_fill2", 32'(fill), 2);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd200;
        #1;
        chk("t5_clear_in_ready", 32'(in_ready), 0);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("t5_clear_fill", 32'(fill), 0);
        send(8'd1); send(8'd1); send(8'd1); send(8'd1);
        chk("t5_valid", 32'(out_valid), 1);
        chk("t5_data",  32'(out_data),  E_4);

        // clear while holding a result
        out_ready = 1'b0;
        tick();
        chk("t5_hold", 32'(out_valid), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_clear_hold_valid", 32'(out_valid), 0);
        #1;
        chk("t5_clear_ready", 32'(in_ready), 1);

        // async reset mid-window
        out_ready = 1'b1;
        send(8'd3); send(8'd3); send(8'd3); send(8'd3);
        chk("t6_data_pre", 32'(out_data), E_12);
        tick();
        send(8'd9); send(8'd9);
        chk("t6_fill2", 32'(fill), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_data",  32'(out_data),  0);
        chk("t6_rst_fill",  32'(fill),      0);
        tick();
        rst_n = 1'b1;
        send(8'd5); send(8'd5); send(8'd5); send(8'd5);
        chk("t6_valid", 32'(out_valid), 1);
        chk("t6_data",  32'(out_data),  E_20);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
